bottle_box_counter: RTL

Counts wine bottles passing the filling-station optical sensor and packs them into boxes of a configurable size. Conditions the raw sensor (synchronise, debounce, rising-edge detect), drives the conveyor run command, and halts the belt when a box is full until the operator acknowledges the box swap. Its 5-bit `count` output feeds directly into `bin_to_bcd` for the two-digit seven-segment display.

---
 rtl/bottle_box_counter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/bottle_box_counter.sv
// ============================================================================
// Module   : bottle_box_counter
// Purpose  : Debounced bottle counter that packs bottles into boxes and gates
//            the conveyor belt.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bottle_box_counter #(
    parameter int BOX_SIZE        = 12,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sensor_raw,
    input  logic       start,
    input  logic       clear,
    input  logic       box_ack,
    output logic [4:0] count,
    output logic       belt_run,
    output logic       box_full,
    output logic       overflow
);

    localparam logic [4:0] c_BOX_SIZE = 5'(BOX_SIZE);
    localparam logic [7:0] c_DB_LAST  = 8'(DEBOUNCE_CYCLES - 1);

    if (BOX_SIZE < 1 || BOX_SIZE > 31) begin : g_bad_box_size
        $error("BOX_SIZE must be in 1..31");
    end
    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be in 2..255");
    end

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COUNTING = 2'd1,
        ST_FULL     = 2'd2
    } state_t;

    logic       r_s1;
    logic       r_s2;
    logic       r_filtered;
    logic       r_filt_prev;
    logic [7:0] r_db_cnt;
    logic       w_bottle;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [4:0] r_count;
    logic [4:0] w_count_nxt;
    logic       r_belt_run;
    logic       w_belt_run_nxt;
    logic       r_box_full;
    logic       w_box_full_nxt;
    logic       r_overflow;
    logic       w_overflow_nxt;

    // Sensor conditioning: synchroniser, stability counter, rising-edge detect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1        <= 1'b0;
            r_s2        <= 1'b0;
            r_filtered  <= 1'b0;
            r_filt_prev <= 1'b0;
            r_db_cnt    <= 8'd0;
        end else begin
            r_s1        <= sensor_raw;
            r_s2        <= r_s1;
            r_filt_prev <= r_filtered;
            if (r_s2 == r_filtered) begin
                r_db_cnt <= 8'd0;
            end else if (r_db_cnt == c_DB_LAST) begin
                r_filtered <= r_s2;
                r_db_cnt   <= 8'd0;
            end else begin
                r_db_cnt <= r_db_cnt + 8'd1;
            end
        end
    end

    assign w_bottle = r_filtered & ~r_filt_prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_count    <= 5'd0;
            r_belt_run <= 1'b0;
            r_box_full <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_belt_run <= w_belt_run_nxt;
            r_box_full <= w_box_full_nxt;
            r_overflow <= w_overflow_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_count_nxt    = r_count;
        w_belt_run_nxt = r_belt_run;
        w_box_full_nxt = r_box_full;
        w_overflow_nxt = r_overflow;

        if (clear) begin
            w_state_nxt    = ST_IDLE;
            w_count_nxt    = 5'd0;
            w_belt_run_nxt = 1'b0;
            w_box_full_nxt = 1'b0;
            w_overflow_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_state_nxt    = ST_COUNTING;
                        w_belt_run_nxt = 1'b1;
                    end
                end
                ST_COUNTING: begin
                    if (w_bottle) begin
                        w_count_nxt = r_count + 5'd1;
                        if (r_count + 5'd1 == c_BOX_SIZE) begin
                            w_state_nxt    = ST_FULL;
                            w_box_full_nxt = 1'b1;
                            w_belt_run_nxt = 1'b0;
                        end
                    end
                end
                ST_FULL: begin
                    if (box_ack) begin
                        w_overflow_nxt = 1'b0;
                        // A bottle arriving with the ack goes into the fresh box.
                        if (w_bottle) begin
                            w_count_nxt = 5'd1;
                            if (c_BOX_SIZE == 5'd1) begin
                                w_state_nxt    = ST_FULL;
                                w_box_full_nxt = 1'b1;
                                w_belt_run_nxt = 1'b0;
                            end else begin
                                w_state_nxt    = ST_COUNTING;
                                w_box_full_nxt = 1'b0;
                                w_belt_run_nxt = 1'b1;
                            end
                        end else begin
                            w_count_nxt    = 5'd0;
                            w_state_nxt    = ST_COUNTING;
                            w_box_full_nxt = 1'b0;
                            w_belt_run_nxt = 1'b1;
                        end
                    end else if (w_bottle) begin
                        w_overflow_nxt = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt    = ST_IDLE;
                    w_count_nxt    = 5'd0;
                    w_belt_run_nxt = 1'b0;
                    w_box_full_nxt = 1'b0;
                    w_overflow_nxt = 1'b0;
                end
            endcase
        end
    end

    assign count    = r_count;
    assign belt_run = r_belt_run;
    assign box_full = r_box_full;
    assign overflow = r_overflow;

endmodule

`default_nettype wire
